// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared state encoding and parameter defaults for the fetch sequencer.
// Rev 1.0
`default_nettype none

package cpu_ctrl_pkg;

  localparam int c_addr_w_def   = 8;
  localparam int c_instr_w_def  = 16;
  localparam int c_reset_pc_def = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_incr.sv
// pc_incr -- program counter incrementer, wraps silently modulo 2^ADDR_W.
// Rev 1.0
`default_nettype none

module pc_incr #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_out
);

  assign pc_out = pc_in + ADDR_W'(1);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- IDLE/FETCH/EXEC/HALTED instruction fetch controller with PC and IR.
// Rev 1.0
`default_nettype none

module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = c_addr_w_def,
  parameter int                INSTR_W  = c_instr_w_def,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc_def)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               exec_done,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_exec_first;

  pc_incr #(
    .ADDR_W (ADDR_W)
  ) u_pc_incr (
    .pc_in  (r_pc),
    .pc_out (w_pc_inc)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (run)       w_state_nxt = FETCH;
      FETCH:   if (mem_ack)   w_state_nxt = EXEC;
      EXEC:    if (exec_done) w_state_nxt = halt ? HALTED : FETCH;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_exec_first marks the first EXEC cycle so ir_valid stays a pure register decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_exec_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_exec_first <= 1'b0;
      if (r_state == FETCH && mem_ack) begin
        r_ir         <= mem_rdata;
        r_pc         <= w_pc_inc;
        r_exec_first <= 1'b1;
      end else if (r_state == EXEC && exec_done && !halt && jump_en) begin
        r_pc <= jump_addr;
      end
    end
  end

  assign mem_req  = (r_state == FETCH);
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign ir       = r_ir;
  assign ir_valid = (r_state == EXEC) && r_exec_first;
  assign busy     = (r_state == FETCH) || (r_state == EXEC);
  assign halted   = (r_state == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer -- directed scoreboard bench for fetch_sequencer.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1, run = 1'b0, mem_ack = 1'b0;
  logic          exec_done = 1'b0, jump_en = 1'b0, halt = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic [AW-1:0] jump_addr = '0;
  logic          mem_req, ir_valid, busy, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [IW-1:0] ir;

  logic          w_rst = 1'b1, w_run = 1'b0, w_mem_ack = 1'b0, w_exec_done = 1'b0;
  logic [IW-1:0] w_mem_rdata = '0;
  logic          w_mem_req, w_ir_valid, w_busy, w_halted;
  logic [AW-1:0] w_mem_addr, w_pc;
  logic [IW-1:0] w_ir;

  int vectors = 0;
  int miscompares = 0;
  logic [IW-1:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .pc(pc), .busy(busy), .halted(halted)
  );

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst(w_rst), .run(w_run), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .ir(w_ir), .ir_valid(w_ir_valid),
    .exec_done(w_exec_done), .jump_en(1'b0), .jump_addr(8'h00), .halt(1'b0),
    .pc(w_pc), .busy(w_busy), .halted(w_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic obs_valid, input logic [IW-1:0] obs_ir);
    logic [IW-1:0] e;
    chk({tag, "_ir_valid"}, 32'(obs_valid), 32'd1);
    vectors++;
    assert (sb_q.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sb_underflow observed=%0h expected=nonempty", tag, obs_ir);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_ir"}, 32'(obs_ir), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold_mem_req", 32'(mem_req), 32'd0);
    run = 1'b1;
    tick();
    run = 1'b0;

    // Sequential run: one instruction per two cycles
    exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_mem_req", 32'(mem_req), 32'd1);
      chk("seq_mem_addr", 32'(mem_addr), 32'(i));
      chk("seq_no_ir_valid_in_fetch", 32'(ir_valid), 32'd0);
      mem_ack = 1'b1;
      mem_rdata = IW'(16'hA000 + i);
      sb_q.push_back(mem_rdata);
      tick();
      mem_ack = 1'b0;
      sb_pop("seq", ir_valid, ir);
      chk("seq_pc", 32'(pc), 32'(i + 1));
      chk("seq_busy", 32'(busy), 32'd1);
      tick();
    end

    // Memory wait at address 5
    chk("pre_wait_addr", 32'(mem_addr), 32'h4);
    mem_ack = 1'b1;
    mem_rdata = 16'hA004;
    sb_q.push_back(mem_rdata);
    tick();
    mem_ack = 1'b0;
    sb_pop("pre_wait", ir_valid, ir);
    tick();
    exec_done = 1'b0;
    mem_rdata = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_mem_addr", 32'(mem_addr), 32'h5);
      chk("wait_ir_hold", 32'(ir), 32'hA004);
      tick();
    end
    chk("wait_ack_mem_req", 32'(mem_req), 32'd1);
    chk("wait_ack_mem_addr", 32'(mem_addr), 32'h5);
    mem_ack = 1'b1;
    mem_rdata = 16'h5555;
    sb_q.push_back(mem_rdata);
    tick();
    sb_pop("wait", ir_valid, ir);
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("exec_ir_valid_once", 32'(ir_valid), 32'd0);
    chk("exec_ack_ignored_ir", 32'(ir), 32'h5555);
    chk("exec_ack_ignored_pc", 32'(pc), 32'h6);
    chk("exec_wait_busy", 32'(busy), 32'd1);

    // Jump: pulse outside EXEC ignored, then jump from EXEC
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("fetch6_addr", 32'(mem_addr), 32'h6);
    jump_en = 1'b1;
    jump_addr = 8'h40;
    tick();
    jump_en = 1'b0;
    chk("jump_outside_exec_addr", 32'(mem_addr), 32'h6);
    chk("jump_outside_exec_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 16'h6666;
    sb_q.push_back(mem_rdata);
    tick();
    mem_ack = 1'b0;
    sb_pop("fetch6", ir_valid, ir);
    chk("fetch6_pc", 32'(pc), 32'h7);
    exec_done = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h40;
    tick();
    exec_done = 1'b0;
    jump_en = 1'b0;
    chk("jump_mem_addr", 32'(mem_addr), 32'h40);
    chk("jump_mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 16'h4040;
    sb_q.push_back(mem_rdata);
    tick();
    mem_ack = 1'b0;
    sb_pop("jump", ir_valid, ir);
    chk("jump_pc_inc", 32'(pc), 32'h41);
    exec_done = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h06;
    tick();
    exec_done = 1'b0;
    jump_en = 1'b0;
    chk("jump_back_addr", 32'(mem_addr), 32'h6);
    mem_ack = 1'b1;
    mem_rdata = 16'h0707;
    sb_q.push_back(mem_rdata);
    tick();
    mem_ack = 1'b0;
    sb_pop("pre_halt", ir_valid, ir);
    chk("pre_halt_pc", 32'(pc), 32'h7);

    // Halt wins over jump
    exec_done = 1'b1;
    halt = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h10;
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'h7);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_mem_req", 32'(mem_req), 32'd0);
    run = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hFFFF;
    tick(); tick();
    chk("halt_absorb_halted", 32'(halted), 32'd1);
    chk("halt_absorb_pc", 32'(pc), 32'h7);
    chk("halt_absorb_ir", 32'(ir), 32'h0707);
    chk("halt_absorb_req", 32'(mem_req), 32'd0);
    run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; halt = 1'b0; jump_en = 1'b0;

    // Reset mid-FETCH with mem_ack
    rst = 1'b1;
    tick();
    chk("rst_leaves_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("rst_fetch_req", 32'(mem_req), 32'd1);
    chk("rst_fetch_addr", 32'(mem_addr), 32'h0);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    chk("rst_mid_ir", 32'(ir), 32'h0);
    chk("rst_mid_pc", 32'(pc), 32'h0);
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ir_valid", 32'(ir_valid), 32'd0);
    rst = 1'b0;
    mem_ack = 1'b0;
    tick();
    chk("post_rst_idle_req", 32'(mem_req), 32'd0);
    chk("post_rst_idle_ir", 32'(ir), 32'h0);

    // PC wrap on a RESET_PC=0xFF instance
    chk("wrap_rst_pc", 32'(w_pc), 32'hFF);
    chk("wrap_rst_req", 32'(w_mem_req), 32'd0);
    w_rst = 1'b0;
    w_run = 1'b1;
    tick();
    w_run = 1'b0;
    chk("wrap_fetch_addr", 32'(w_mem_addr), 32'hFF);
    w_mem_ack = 1'b1;
    w_mem_rdata = 16'h7777;
    w_exec_done = 1'b1;
    sb_q.push_back(w_mem_rdata);
    tick();
    w_mem_ack = 1'b0;
    sb_pop("wrap", w_ir_valid, w_ir);
    chk("wrap_pc", 32'(w_pc), 32'h0);
    tick();
    chk("wrap_next_addr", 32'(w_mem_addr), 32'h0);
    chk("wrap_next_req", 32'(w_mem_req), 32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, default 8, sets the program counter and memory address width.
REQ-003 Parameter INSTR_W, default 16, sets the instruction word width.
REQ-004 Parameter RESET_PC, default 0, is the PC value loaded on reset.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  start fetching from IDLE
- mem_req  out  1  instruction read request
- mem_addr  out  ADDR_W  instruction address; equals pc
- mem_ack  in  1  read data valid, one-cycle pulse
- mem_rdata  in  INSTR_W  instruction word, valid with mem_ack
- ir  out  INSTR_W  instruction register
- ir_valid  out  1  one-cycle strobe, new instruction in ir
- exec_done  in  1  execute unit finished the current instruction
- jump_en  in  1  load jump_addr into PC, sampled with exec_done
- jump_addr  in  ADDR_W  jump target
- halt  in  1  stop after the current instruction, sampled with exec_done
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH or EXEC
- halted  out  1  high in HALTED

Function
REQ-006 The FSM SHALL have four states: IDLE, FETCH, EXEC and HALTED.
REQ-007 IDLE: when run=1, the FSM SHALL go to FETCH on the next cycle; otherwise it SHALL stay in IDLE. run SHALL be ignored in every other state.
REQ-008 FETCH: mem_req SHALL be 1 and mem_addr SHALL equal pc; both SHALL be held until mem_ack=1.
REQ-009 A mem_ack in FETCH SHALL cause, on the same edge: ir<=mem_rdata, pc<=(pc+1) mod 2^ADDR_W, and a move to EXEC. Minimum FETCH dwell is 1 cycle.
REQ-010 mem_ack outside FETCH SHALL be ignored, with no change to ir or pc.
REQ-011 ir_valid SHALL be 1 only in the first cycle of each EXEC visit.
REQ-012 EXEC SHALL wait for exec_done=1. exec_done in the same cycle as ir_valid is legal and gives a 1-cycle EXEC.
REQ-013 On exec_done in EXEC, the following priority SHALL apply:
- halt=1: go to HALTED; pc is not changed and jump_en is ignored.
- else jump_en=1: pc<=jump_addr, then go to FETCH.
- else: go to FETCH, keeping the already-incremented pc.
REQ-014 exec_done, jump_en and halt SHALL be ignored outside EXEC.
REQ-015 HALTED SHALL be absorbing; only rst leaves it. pc and ir SHALL hold.
REQ-016 PC wrap SHALL be silent: fetching at 2^ADDR_W-1 leaves pc=0. No overflow flag is produced.
REQ-017 Minimum throughput SHALL be one instruction per 2 cycles (1 FETCH + 1 EXEC).
REQ-018 mem_req, ir_valid, busy and halted SHALL be decoded from state only, with no combinational path from any input.

Reset
REQ-019 While rst=1, the following SHALL be forced on every edge:
- state=IDLE, pc=RESET_PC, ir=0
- mem_req=0, ir_valid=0, busy=0, halted=0
REQ-020 rst SHALL override all other inputs in every state, including mid-FETCH with mem_ack=1 and mid-EXEC with exec_done=1; no ir or pc update SHALL occur on that edge.
REQ-021 After rst falls, the block SHALL stay in IDLE until run=1.

Structure
REQ-022 Package cpu_ctrl_pkg SHALL hold:
- the state encoding (IDLE=0, FETCH=1, EXEC=2, HALTED=3)
- the ADDR_W and INSTR_W defaults
- the RESET_PC default
REQ-023 PC+1 SHALL be computed by one instance of sub-module pc_incr (ADDR_W in, ADDR_W out, out=in+1). The PC register, IR and FSM SHALL live in fetch_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Sequential run: rst, then run=1, mem_ack 1 cycle after each request, exec_done with ir_valid -> mem_addr 0,1,2,3 on successive fetches; ir_valid every 2nd cycle.
- Memory wait: mem_ack delayed 3 cycles -> mem_req and mem_addr=5 held stable for 4 cycles; ir captured only on the ack cycle.
- Jump: exec_done=1, jump_en=1, jump_addr=0x40 -> next mem_addr=0x40; a jump_en pulse outside EXEC has no effect.
- Halt priority: exec_done=1, halt=1, jump_en=1, jump_addr=0x10 at pc=7 -> HALTED, pc stays 7, halted=1; later run and mem_ack are ignored.
- Wrap: RESET_PC=0xFF, fetch one instruction -> pc=0x00, next mem_addr=0x00.
- Reset mid-operation: rst=1 in FETCH coincident with mem_ack, ir=0xBEEF on the bus -> ir=0, pc=RESET_PC, state IDLE, mem_req=0 the next cycle.
